// File: rtl/ysyx_23060061_ifu_pkg.sv
// rtl/ysyx_23060061_ifu_pkg.sv - shared IFU state encodings and reset constants
package ysyx_23060061_ifu_pkg;

  localparam logic [31:0] ysyx_23060061_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ysyx_23060061_INST_NOP  = 32'h0000_0013;

  typedef enum logic [2:0] {
    ysyx_23060061_IFU_RESET    = 3'd0,
    ysyx_23060061_IFU_REQ      = 3'd1,
    ysyx_23060061_IFU_WAIT_RSP = 3'd2,
    ysyx_23060061_IFU_HOLD     = 3'd3,
    ysyx_23060061_IFU_WAIT_PC  = 3'd4,
    ysyx_23060061_IFU_HALT     = 3'd5
  } ifuState_e;

  // A fetch address is legal only when word aligned.
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060061_ifu_perf_counter.sv
// rtl/ysyx_23060061_ifu_perf_counter.sv - 64-bit saturating event counter with enable
module ysyx_23060061_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [63:0] cnt
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// rtl/ysyx_23060061_ifu.sv - multi-cycle instruction fetch unit; YSYX_23060061_IFU_PERF_EN adds perf counters
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_23060061_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            pc_upd_valid,
  input  logic [XLEN-1:0] pc_upd_next,
  input  logic            halt,
`ifdef YSYX_23060061_IFU_PERF_EN
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt,
`endif
  output logic            halted
);

  ifuState_e       state;
  ifuState_e       stateNext;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instReg;
  logic [XLEN-1:0] instPcReg;
  logic            faultReg;
  logic            nextMisaligned;
  logic            pcUpdTaken;
  logic            rspTaken;

  assign nextMisaligned = !isWordAligned(pc_upd_next[1:0]);
  assign pcUpdTaken     = (state == ysyx_23060061_IFU_WAIT_PC) && pc_upd_valid;
  assign rspTaken       = (state == ysyx_23060061_IFU_WAIT_RSP) && imem_rsp_valid;

  // Outputs decode straight from state, so they hold steady until the handshake moves it.
  assign imem_req_valid = (state == ysyx_23060061_IFU_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == ysyx_23060061_IFU_HOLD);
  assign inst           = instReg;
  assign inst_pc        = instPcReg;
  assign inst_fault     = faultReg;
  assign halted         = (state == ysyx_23060061_IFU_HALT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ysyx_23060061_IFU_RESET;
    else        state <= stateNext;
  end

  // Next-state: one instruction in flight, a misaligned next PC faults without touching memory.
  always_comb begin
    stateNext = state;
    case (state)
      ysyx_23060061_IFU_RESET:    stateNext = ysyx_23060061_IFU_REQ;
      ysyx_23060061_IFU_REQ:      if (imem_req_ready) stateNext = ysyx_23060061_IFU_WAIT_RSP;
      ysyx_23060061_IFU_WAIT_RSP: if (imem_rsp_valid) stateNext = ysyx_23060061_IFU_HOLD;
      ysyx_23060061_IFU_HOLD:     if (inst_ready)     stateNext = ysyx_23060061_IFU_WAIT_PC;
      ysyx_23060061_IFU_WAIT_PC: begin
        if (pc_upd_valid) begin
          if (halt)                stateNext = ysyx_23060061_IFU_HALT;
          else if (nextMisaligned) stateNext = ysyx_23060061_IFU_HOLD;
          else                     stateNext = ysyx_23060061_IFU_REQ;
        end
      end
      ysyx_23060061_IFU_HALT:     stateNext = ysyx_23060061_IFU_HALT;
      default:                    stateNext = ysyx_23060061_IFU_RESET;
    endcase
  end

  // PC and the instruction slot presented to the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instReg   <= '0;
      instPcReg <= '0;
      faultReg  <= 1'b0;
    end else begin
      if (pcUpdTaken) begin
        pc <= pc_upd_next;
      end
      if (rspTaken) begin
        instReg   <= imem_rsp_data;
        instPcReg <= pc;
        faultReg  <= imem_rsp_err;
      end else if (pcUpdTaken && !halt && nextMisaligned) begin
        instReg   <= '0;
        instPcReg <= pc_upd_next;
        faultReg  <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // Flag protocol misuse by the neighbours; the offending pulses are otherwise ignored.
  always_ff @(posedge clk) begin
    if (rst_n && imem_rsp_valid && (state != ysyx_23060061_IFU_WAIT_RSP))
      $error("ifu: imem_rsp_valid outside WAIT_RSP");
    if (rst_n && pc_upd_valid && (state != ysyx_23060061_IFU_WAIT_PC))
      $error("ifu: pc_upd_valid outside WAIT_PC");
  end
`endif

`ifdef YSYX_23060061_IFU_PERF_EN
  logic fetchEvent;
  logic stallEvent;

  assign fetchEvent = inst_valid && inst_ready;
  assign stallEvent = ((state == ysyx_23060061_IFU_REQ) && !imem_req_ready) ||
                      (state == ysyx_23060061_IFU_WAIT_RSP);

  ysyx_23060061_perf_counter uFetchCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fetchEvent),
    .cnt   (perf_fetch_cnt)
  );

  ysyx_23060061_perf_counter uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stallEvent),
    .cnt   (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// tb/tb_ysyx_23060061_ifu.sv - scoreboard bench for ysyx_23060061_ifu
module tb_ysyx_23060061_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc;
  logic        pc_upd_valid, halt, halted;
  logic [31:0] pc_upd_next;
`ifdef YSYX_23060061_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_23060061_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .pc_upd_valid   (pc_upd_valid),
    .pc_upd_next    (pc_upd_next),
    .halt           (halt),
`ifdef YSYX_23060061_IFU_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .halted         (halted)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } instExp_t;

  typedef struct {
    logic [31:0] pc;
    bit          halt;
    int          stall;
    int          hold;
  } step_t;

  instExp_t    expInst[$];
  logic [31:0] expReq[$];
  step_t       script[$];

  int tests = 0;
  int fails = 0;

  // environment knobs
  int readyPct = 100, iduPct = 100, latFixed = 0, latMax = 0, wbDelayMax = 0;
  int randHaltAt = 1000000;

  // environment state
  bit          acceptFlag = 0, rspPend = 0, hsFlag = 0, wbPend = 0, instSeen = 0;
  bit          staleInject = 0, haltIssued = 0;
  logic [31:0] accAddr = 0, rspAddr = 0, curPc = RST_PC;
  int          rspCnt = 0, stallLeft = 0, holdLeft = 0, wbDelay = 0;
  int          hsCount = 0, hsSinceReset = 0;

  // Memory image: a fixed hash of the address, with a bus error on every word at offset 0x10 of a 128-byte block.
  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == RST_PC) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic memErr(input logic [31:0] a);
    return (a % 32'd128) == 32'd16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] randomNext(input logic [31:0] pc);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return pc + 32'd4 + 32'($urandom_range(1, 3));
    else if (r <= 2) return RST_PC + 32'($urandom_range(0, 16383) * 4);
    else             return pc + 32'd4;
  endfunction

  // Writeback model: supplies the next PC and records what the IFU must do with it.
  task automatic issueUpdate();
    step_t s;
    if (script.size() > 0) begin
      s = script.pop_front();
    end else begin
      s.halt  = (hsCount >= randHaltAt);
      s.pc    = randomNext(curPc);
      s.stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      s.hold  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
    end
    pc_upd_valid = 1'b1;
    pc_upd_next  = s.pc;
    halt         = s.halt;
    stallLeft    = s.stall;
    holdLeft     = s.hold;
    if (s.halt) begin
      haltIssued = 1;
    end else if ((s.pc % 32'd4) != 32'd0) begin
      expInst.push_back('{inst: 32'd0, pc: s.pc, fault: 1'b1});
    end else begin
      expReq.push_back(s.pc);
      expInst.push_back('{inst: memData(s.pc), pc: s.pc, fault: memErr(s.pc)});
    end
    curPc = s.pc;
  endtask

  // Driver: memory, IDU and writeback neighbours, stepped just after each rising edge.
  initial begin
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; imem_rsp_err = 0;
    inst_ready = 0; pc_upd_valid = 0; pc_upd_next = 0; halt = 0;
    forever begin
      @(posedge clk); #1;
      imem_rsp_valid = 0; pc_upd_valid = 0; halt = 0;
      if (!rst_n) begin
        acceptFlag = 0; rspPend = 0; hsFlag = 0; wbPend = 0;
        stallLeft = 0; holdLeft = 0; imem_req_ready = 0; inst_ready = 0;
        if (staleInject) begin
          imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; imem_rsp_err = 1;
          staleInject = 0;
        end
        continue;
      end
      if (acceptFlag) begin
        acceptFlag = 0; rspPend = 1; rspAddr = accAddr;
        rspCnt = (latFixed >= 0) ? latFixed : $urandom_range(0, latMax);
      end
      if (rspPend) begin
        if (rspCnt == 0) begin
          imem_rsp_valid = 1; imem_rsp_data = memData(rspAddr); imem_rsp_err = memErr(rspAddr);
          rspPend = 0;
        end else begin
          rspCnt--;
        end
      end
      if (stallLeft > 0) begin
        imem_req_ready = 0; stallLeft--;
      end else begin
        imem_req_ready = ($urandom_range(1, 100) <= readyPct);
      end
      if (holdLeft > 0) begin
        inst_ready = 0;
        if (instSeen) holdLeft--;
      end else begin
        inst_ready = ($urandom_range(1, 100) <= iduPct);
      end
      if (hsFlag) begin
        hsFlag = 0; wbPend = 1; wbDelay = $urandom_range(0, wbDelayMax);
      end
      if (wbPend) begin
        if (wbDelay == 0) begin
          issueUpdate(); wbPend = 0;
        end else begin
          wbDelay--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request and every IDU handshake.
  bit          prevReqStall = 0, prevInstStall = 0;
  logic [31:0] prevAddr = 0, prevInst = 0, prevInstPc = 0;
  logic        prevFault = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevReqStall = 0; prevInstStall = 0; instSeen = 0;
        continue;
      end
      if (prevReqStall) begin
        check("req_valid_held", 32'(imem_req_valid), 32'd1);
        check("req_addr_held", imem_req_addr, prevAddr);
      end
      if (imem_req_valid) begin
        check("req_expected", 32'(expReq.size() != 0), 32'd1);
        if (imem_req_ready && expReq.size() != 0) begin
          check("req_addr", imem_req_addr, expReq.pop_front());
          acceptFlag = 1; accAddr = imem_req_addr;
        end
      end
      if (inst_valid) begin
        check("inst_before_rsp", 32'(rspPend), 32'd0);
        if (prevInstStall) begin
          check("inst_held", inst, prevInst);
          check("inst_pc_held", inst_pc, prevInstPc);
          check("inst_fault_held", 32'(inst_fault), 32'(prevFault));
        end
        if (inst_ready) begin
          check("inst_expected", 32'(expInst.size() != 0), 32'd1);
          if (expInst.size() != 0) begin
            instExp_t e;
            e = expInst.pop_front();
            check("inst", inst, e.inst);
            check("inst_pc", inst_pc, e.pc);
            check("inst_fault", 32'(inst_fault), 32'(e.fault));
          end
          hsFlag = 1; hsCount++; hsSinceReset++;
        end
      end
      prevReqStall  = imem_req_valid && !imem_req_ready;
      prevAddr      = imem_req_addr;
      prevInstStall = inst_valid && !inst_ready;
      prevInst      = inst;
      prevInstPc    = inst_pc;
      prevFault     = inst_fault;
      instSeen      = inst_valid;
    end
  end

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_inst_fault"}, 32'(inst_fault), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
`ifdef YSYX_23060061_IFU_PERF_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt[31:0], 32'd0);
    check({tag, "_perf_stall"}, perf_stall_cnt[31:0], 32'd0);
`endif
  endtask

  task automatic waitHalt(input int budget, input string tag);
    for (int i = 0; i < budget && !haltIssued; i++) @(posedge clk);
    check({tag, "_halt_reached"}, 32'(haltIssued), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_no_req"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_req_queue_empty"}, 32'(expReq.size()), 32'd0);
    check({tag, "_inst_queue_empty"}, 32'(expInst.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 checkResetOutputs("reset");
    expReq.push_back(RST_PC);
    expInst.push_back('{inst: 32'h0010_0093, pc: RST_PC, fault: 1'b0});
    script.push_back('{pc: 32'h8000_0004, halt: 1'b0, stall: 3, hold: 0});
    script.push_back('{pc: 32'h8000_0008, halt: 1'b0, stall: 0, hold: 4});
    script.push_back('{pc: 32'h8000_0006, halt: 1'b0, stall: 0, hold: 0});
    script.push_back('{pc: 32'h8000_0010, halt: 1'b0, stall: 0, hold: 0});
    script.push_back('{pc: 32'h8000_0014, halt: 1'b1, stall: 0, hold: 0});
    @(posedge clk); #2 rst_n = 1;
    waitHalt(300, "directed");

    // Reset while a response is outstanding; a stale response then arrives during reset.
    @(posedge clk); #2 rst_n = 0;
    haltIssued = 0; hsSinceReset = 0;
    expReq.delete(); expInst.delete(); script.delete();
    expReq.push_back(RST_PC);
    expInst.push_back('{inst: 32'h0010_0093, pc: RST_PC, fault: 1'b0});
    curPc = RST_PC; latFixed = 8;
    @(posedge clk); #2 rst_n = 1;
    for (int i = 0; i < 50 && expReq.size() != 0; i++) @(posedge clk);
    check("reset_test_accepted", 32'(expReq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    staleInject = 1;
    expReq.delete(); expInst.delete();
    repeat (2) @(posedge clk);
    #2 checkResetOutputs("midreset");
    expReq.push_back(RST_PC);
    expInst.push_back('{inst: 32'h0010_0093, pc: RST_PC, fault: 1'b0});
    curPc = RST_PC; hsSinceReset = 0;
    latFixed = -1; latMax = 3; readyPct = 60; iduPct = 60; wbDelayMax = 3;
    randHaltAt = hsCount + 150;
    @(posedge clk); #2 rst_n = 1;
    waitHalt(20000, "random");
`ifdef YSYX_23060061_IFU_PERF_EN
    check("perf_fetch_total", perf_fetch_cnt[31:0], 32'(hsSinceReset));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_ifu.md
Name: ysyx_23060061_ifu

Overview:
Instruction fetch unit for the multi-cycle NPC core, and the producer side of the decoder's instruction input. It holds the PC and issues one word-aligned read per instruction over a valid/ready request channel to instruction memory. It captures the response and presents {inst, pc} to the decoder/IDU through a valid/ready handshake. It does not fetch again until writeback returns the next PC, so at most one instruction is in flight.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; must be 4-byte aligned.
XLEN, 32, width of PC, address and instruction.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  read data valid (one-cycle pulse)
imem_rsp_data  in  XLEN  instruction word
imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
inst_valid  out  1  instruction available to IDU
inst_ready  in  1  IDU accepts instruction
inst  out  XLEN  instruction word to decoder
inst_pc  out  XLEN  PC of inst
inst_fault  out  1  instruction-fetch fault (bus error or misaligned PC)
pc_upd_valid  in  1  writeback supplies next PC
pc_upd_next  in  XLEN  next PC
halt  in  1  ebreak committed; qualified by pc_upd_valid
halted  out  1  fetch permanently stopped

Behaviour:
- Reset (async assert, sync-deassert tolerant): state=RESET, pc=RESET_PC, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, halted=0.
- States:
  - RESET -> REQ on the first clock after rst_n high.
  - REQ: imem_req_valid=1, addr=pc. On req_valid && req_ready, go to WAIT_RSP.
  - WAIT_RSP: on rsp_valid, latch inst=rsp_data, inst_pc=pc, inst_fault=rsp_err, then go to HOLD.
  - HOLD: inst_valid=1. Outputs stay stable until inst_ready. On handshake, go to WAIT_PC.
  - WAIT_PC: on pc_upd_valid, pc<=pc_upd_next.
    - If halt=1, go to HALT.
    - Else if pc_upd_next[1:0]!=0, go to HOLD with inst=0, inst_pc=pc_upd_next, inst_fault=1, and no memory request.
    - Else go to REQ.
  - HALT: terminal. halted=1, no requests. Only reset leaves this state.
- Latency: request asserted 1 cycle after entering REQ's predecessor transition. inst_valid rises the cycle after rsp_valid, so minimum fetch-to-inst is 1 cycle after memory response. With zero-wait memory (ready=1, rsp next cycle), pc update to inst_valid takes 3 cycles.
- imem_req_valid is never dropped before ready. addr is stable while valid.
- rsp_valid is ignored outside WAIT_RSP. pc_upd_valid is ignored outside WAIT_PC. Both are flagged by a simulation-only $error.
- Back-to-back: inst_ready may be held high. rsp_valid in the same cycle as req acceptance is illegal; the memory gives ≥1 cycle latency.
- Reset mid-operation: pending request and response are dropped. The memory side is reset by the same rst_n.
- PC arithmetic is XLEN bits, wraps modulo 2^XLEN. The IFU does no increment itself.

Optional Feature:
YSYX_23060061_IFU_PERF_EN:
- Defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt increments on each IDU handshake.
  - perf_stall_cnt increments on every cycle in REQ with !req_ready, or in WAIT_RSP.
  - Both saturate at all-ones.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- global.vh defines:
  - IFU state encodings ysyx_23060061_IFU_RESET/REQ/WAIT_RSP/HOLD/WAIT_PC/HALT, 3-bit.
  - ysyx_23060061_RESET_PC.
  - ysyx_23060061_INST_NOP = 32'h0000_0013.
- State register uses the existing register primitive with reset value.
- One sub-module: ysyx_23060061_perf_counter, a 64-bit saturating counter with enable, instantiated twice only under the macro.

Test Plan:
1. Reset release, mem ready=1, rsp next cycle with data 32'h00100093:
   - req addr 32'h80000000.
   - inst_valid with inst=32'h00100093, inst_pc=32'h80000000, fault=0.
2. Memory stalls 3 cycles (req_ready=0):
   - req_valid and addr are held stable all 3 cycles.
   - Exactly one accepted request; no inst_valid before response.
3. IDU backpressure: inst_ready=0 for 4 cycles:
   - inst, inst_pc and inst_valid are stable.
   - No new request issued until pc_upd_valid after handshake.
4. pc_upd_next=32'h80000006:
   - No memory request.
   - inst_valid with inst=0, inst_pc=32'h80000006, inst_fault=1.
5. Response with imem_rsp_err=1 at pc 32'h80000010:
   - inst_fault=1 presented.
   - halt=1 with pc_upd_valid leads to halted=1 and no further req_valid for 20 cycles.
6. rst_n asserted while in WAIT_RSP, then a stale rsp_valid arrives:
   - The stale response is ignored.
   - After release, fetch restarts at 32'h80000000.
   - With PERF_EN, counters read 0.
